fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences a dual_port_ram instance (write port plus combinational read port) into a first-word-fall-through FIFO.
- Owns the read/write pointers, occupancy count, status flags and sticky error flags.
- Drives the RAM's we, w_addr and r_addr.
- Sits between the producer/consumer logic and the RAM inside the FIFO top level.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 106 ++++++++++
 tb/tb_fifo_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers for the FIFO controller and its pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 3;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // One extra MSB is carried as the wrap bit to tell full from empty.
    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrap-bit pointer register with async reset, sync clear, increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    localparam logic [PTR_W-1:0] c_ONE = PTR_W'(1);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + c_ONE;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : FWFT FIFO controller driving a dual-port RAM (pointers, count, flags).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_PW       = ptr_width(ADDR_WIDTH);
    localparam logic [c_PW-1:0]   c_ONE      = c_PW'(1);
    localparam logic [c_PW-1:0]   c_AF_LEVEL = c_PW'(AF_LEVEL);
    localparam logic [c_PW-1:0]   c_AE_LEVEL = c_PW'(AE_LEVEL);

    logic [c_PW-1:0] w_wr_ptr;
    logic [c_PW-1:0] w_rd_ptr;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic [c_PW-1:0] r_count;
    logic            r_overflow;
    logic            r_underflow;

    // Status comes from registered pointers only; inputs never reach the flags.
    assign w_full  = (w_wr_ptr[c_PW-1] != w_rd_ptr[c_PW-1]) &&
                     (w_wr_ptr[c_PW-2:0] == w_rd_ptr[c_PW-2:0]);
    assign w_empty = (w_wr_ptr == w_rd_ptr);

    assign w_wr_ok = wr & (~w_full | rd);
    assign w_rd_ok = rd & ~w_empty;

    fifo_ptr #(.PTR_W(c_PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (clr),
        .i_inc (w_wr_ok),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.PTR_W(c_PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (clr),
        .i_inc (w_rd_ok),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + c_ONE;
            end else if (!w_wr_ok && w_rd_ok) begin
                r_count <= r_count - c_ONE;
            end
            if (wr && w_full && !rd) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign we           = w_wr_ok & ~clr;
    assign w_addr       = w_wr_ptr[c_PW-2:0];
    assign r_addr       = w_rd_ptr[c_PW-2:0];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Self-checking bench for fifo_ctrl with a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       we;
    logic [2:0] w_addr;
    logic [2:0] r_addr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [DEPTH];

    logic [7:0] mq[$];
    int unsigned m_wp = 0;
    int unsigned m_rp = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .rd           (rd),
        .clr          (clr),
        .we           (we),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the dual-port RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (we) mem[w_addr] <= din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wp  = 0;
        m_rp  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
        chk("w_addr", 32'(w_addr), m_wp % DEPTH);
        chk("r_addr", 32'(r_addr), m_rp % DEPTH);
        chk("ptr_diff", 32'(3'(w_addr - r_addr)), 32'(n % DEPTH));
    endtask

    task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
        int  n;
        bit  wok;
        bit  rok;
        @(negedge clk);
        check_state();
        wr  = w;
        rd  = r;
        clr = c;
        din = d;
        #1;
        n   = mq.size();
        wok = w && (n < DEPTH || r);
        rok = r && (n > 0);
        chk("we", 32'(we), 32'(wok && !c));
        if (n > 0) chk("q", 32'(mem[r_addr]), 32'(mq[0]));
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (w && n == DEPTH && !r) m_ovf = 1'b1;
            if (r && n == 0) m_udf = 1'b1;
            if (rok) begin
                void'(mq.pop_front());
                m_rp = (m_rp + 1) % (2 * DEPTH);
            end
            if (wok) begin
                mq.push_back(d);
                m_wp = (m_wp + 1) % (2 * DEPTH);
            end
        end
    endtask

    initial begin
        int pw;
        int pr;
        model_reset();
        #12;
        rst_n = 1'b1;

        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        for (int i = 1; i <= 8; i++) cycle(1, 0, 0, 8'(i * 8'h11));
        cycle(1, 0, 0, 8'hEE);
        cycle(0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);

        for (int i = 1; i <= 8; i++) cycle(1, 0, 0, 8'(i * 8'h11));
        cycle(1, 1, 0, 8'h99);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h00);
        cycle(1, 1, 0, 8'h5A);
        cycle(0, 0, 0, 8'h00);

        cycle(1, 0, 0, 8'h3C);
        cycle(1, 0, 1, 8'hC3);
        cycle(0, 0, 0, 8'h00);

        for (int i = 0; i < 20; i++) cycle(1'(i % 3 != 2), 1'(i % 2), 0, 8'($urandom));

        for (int i = 0; i < 400; i++) begin
            pw = (i / 50) % 2 ? 30 : 70;
            pr = 100 - pw;
            cycle(1'($urandom_range(99) < pw), 1'($urandom_range(99) < pr),
                  1'($urandom_range(99) < 2), 8'($urandom));
        end

        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'($urandom));
        @(negedge clk);
        wr = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        wr = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("we_rst", 32'(we), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 8'hA5);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
